// File: rtl/perceptron_train_ctrl.sv
// Perceptron training sequencer.
// Filters branch resolutions with the perceptron training rule, queues the ones
// that need training, and gives each queued entry one table read cycle followed
// by one train-unit write cycle. The table read port is shared with fetch:
// fetch wins arbitration until the starvation guard forces a training slot.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush_i             drop all pending training
//   res_*               resolution input channel (valid/ready)
//   if_rd_req_i         fetch wants the table read port this cycle
//   if_stall_o          fetch denied the port this cycle
//   pt_rd_en_o/idx_o    training read of the perceptron table
//   tr_*                write command to the train unit
//   busy_o              work pending or in progress
//   trained_cnt_o       entries written (wrapping)
//   skipped_cnt_o       accepted resolutions filtered out (wrapping)
module perceptron_train_ctrl #(
  parameter int unsigned PT_IDX_W  = 6,
  parameter int unsigned BHR_W     = 8,
  parameter int unsigned WEIGHT_W  = 8,
  parameter int unsigned THRESHOLD = 20,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned STALL_MAX = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic                res_vld_i,
  output logic                res_rdy_o,
  input  logic [PT_IDX_W-1:0] res_idx_i,
  input  logic                res_outcome_i,
  input  logic [BHR_W-1:0]    res_bhr_i,
  input  logic [WEIGHT_W-1:0] res_y_i,
  input  logic                if_rd_req_i,
  output logic                if_stall_o,
  output logic                pt_rd_en_o,
  output logic [PT_IDX_W-1:0] pt_rd_idx_o,
  output logic                tr_en_o,
  output logic [PT_IDX_W-1:0] tr_idx_o,
  output logic                tr_outcome_o,
  output logic [BHR_W-1:0]    tr_bhr_o,
  output logic                busy_o,
  output logic [15:0]         trained_cnt_o,
  output logic [15:0]         skipped_cnt_o
);

  localparam int unsigned ENT_W = PT_IDX_W + 1 + BHR_W;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned STL_W = (STALL_MAX > 0) ? $clog2(STALL_MAX + 1) : 1;
  localparam logic [WEIGHT_W:0] THRESH   = (WEIGHT_W + 1)'(THRESHOLD);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [STL_W-1:0]  STL_LIM  = STL_W'(STALL_MAX);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_e;

  state_e             state_q, state_d;
  logic [ENT_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [STL_W-1:0]   stall_q, stall_d;
  logic [ENT_W-1:0]   hold_q, hold_d;
  logic [15:0]        trained_q, trained_d, skipped_q, skipped_d;

  logic               y_neg, need_c, full_c, accept_c, push_c, pop_c, grant_c;
  logic [WEIGHT_W:0]  y_ext, y_abs;
  logic [ENT_W-1:0]   head_c;

  // Training rule: mispredicted, or |y| not above threshold. |y| is one bit
  // wider so the most negative weight sum stays positive.
  assign y_neg  = res_y_i[WEIGHT_W-1];
  assign y_ext  = {y_neg, res_y_i};
  assign y_abs  = y_neg ? -y_ext : y_ext;
  assign need_c = ((~y_neg) != res_outcome_i) | (y_abs <= THRESH);

  assign full_c    = (count_q == FULL_CNT);
  assign res_rdy_o = ~full_c;
  assign accept_c  = res_vld_i & ~full_c & ~flush_i;
  assign push_c    = accept_c & need_c;
  assign head_c    = mem_q[rd_ptr_q];

  // Fetch owns the port unless the stall counter has hit its limit.
  assign grant_c = ~if_rd_req_i | (stall_q == STL_LIM);
  assign pop_c   = (state_q == S_READ) & grant_c & ~flush_i;

  // FIFO pointer and occupancy update; flush empties it outright.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Next state and cycle outputs. Transitions look at next-cycle occupancy so
  // an entry accepted this cycle is read in the very next cycle.
  always_comb begin
    state_d    = state_q;
    stall_d    = stall_q;
    hold_d     = hold_q;
    trained_d  = trained_q;
    skipped_d  = skipped_q;
    pt_rd_en_o = 1'b0;
    if_stall_o = 1'b0;
    tr_en_o    = 1'b0;
    if (accept_c && !need_c) skipped_d = skipped_q + 16'd1;
    case (state_q)
      S_IDLE: begin
        if (count_d != '0) state_d = S_READ;
      end
      S_READ: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (grant_c) begin
          pt_rd_en_o = 1'b1;
          if_stall_o = if_rd_req_i;
          hold_d     = head_c;
          stall_d    = '0;
          state_d    = S_WRITE;
        end else begin
          // Cannot pass STALL_MAX: reaching it forces a grant.
          stall_d = stall_q + STL_W'(1);
        end
      end
      S_WRITE: begin
        tr_en_o   = 1'b1;
        trained_d = trained_q + 16'd1;
        state_d   = (count_d != '0) ? S_READ : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i) stall_d = '0;
  end

  assign pt_rd_idx_o   = pt_rd_en_o ? head_c[ENT_W-1 -: PT_IDX_W] : '0;
  assign tr_idx_o      = tr_en_o ? hold_q[ENT_W-1 -: PT_IDX_W] : '0;
  assign tr_outcome_o  = tr_en_o & hold_q[BHR_W];
  assign tr_bhr_o      = tr_en_o ? hold_q[BHR_W-1:0] : '0;
  assign busy_o        = (count_q != '0) | (state_q != S_IDLE);
  assign trained_cnt_o = trained_q;
  assign skipped_cnt_o = skipped_q;

  // Control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      stall_q   <= '0;
      hold_q    <= '0;
      trained_q <= '0;
      skipped_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      stall_q   <= stall_d;
      hold_q    <= hold_d;
      trained_q <= trained_d;
      skipped_q <= skipped_d;
    end
  end

  // Entry storage; contents are only meaningful below count_q.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= {res_idx_i, res_outcome_i, res_bhr_i};
  end

endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// Self-checking bench for perceptron_train_ctrl: directed latency, back-pressure,
// starvation, flush and reset scenarios plus a randomized phase, all checked by
// a scoreboard fed from a behavioural model of the training rule.
module tb_perceptron_train_ctrl;

  logic        clk, rst, flush_i, res_vld_i, res_rdy_o, res_outcome_i;
  logic [5:0]  res_idx_i, pt_rd_idx_o, tr_idx_o;
  logic [7:0]  res_bhr_i, res_y_i, tr_bhr_o;
  logic        if_rd_req_i, if_stall_o, pt_rd_en_o, tr_en_o, tr_outcome_o, busy_o;
  logic [15:0] trained_cnt_o, skipped_cnt_o;

  perceptron_train_ctrl dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .res_vld_i(res_vld_i), .res_rdy_o(res_rdy_o), .res_idx_i(res_idx_i),
    .res_outcome_i(res_outcome_i), .res_bhr_i(res_bhr_i), .res_y_i(res_y_i),
    .if_rd_req_i(if_rd_req_i), .if_stall_o(if_stall_o),
    .pt_rd_en_o(pt_rd_en_o), .pt_rd_idx_o(pt_rd_idx_o),
    .tr_en_o(tr_en_o), .tr_idx_o(tr_idx_o), .tr_outcome_o(tr_outcome_o),
    .tr_bhr_o(tr_bhr_o), .busy_o(busy_o),
    .trained_cnt_o(trained_cnt_o), .skipped_cnt_o(skipped_cnt_o)
  );

  typedef struct {
    logic [5:0] idx;
    logic       outcome;
    logic [7:0] bhr;
  } ent_t;

  ent_t exp_q[$];   // accepted, needing training, not yet read
  ent_t infl_q[$];  // read, awaiting write
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_trained = 0;
  int   exp_skipped = 0;
  bit   last_acc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Reference training rule with plain integer arithmetic.
  function automatic bit need_f(input logic outcome, input logic [7:0] y);
    int yi, a;
    yi = int'($signed(y));
    a  = (yi < 0) ? -yi : yi;
    return ((yi >= 0) != outcome) || (a <= 20);
  endfunction

  // Bookkeeping of this cycle's handshake into the model.
  task automatic book();
    ent_t e;
    last_acc = 0;
    if (rst) begin
      exp_q.delete();
      infl_q.delete();
      exp_trained = 0;
      exp_skipped = 0;
    end else if (flush_i) begin
      exp_trained -= exp_q.size();
      exp_q.delete();
    end else if (res_vld_i && res_rdy_o) begin
      last_acc = 1;
      if (need_f(res_outcome_i, res_y_i)) begin
        e.idx = res_idx_i; e.outcome = res_outcome_i; e.bhr = res_bhr_i;
        exp_q.push_back(e);
        exp_trained++;
      end else begin
        exp_skipped++;
      end
    end
  endtask

  // Monitor: every read must match the oldest pending entry, every write the
  // oldest read entry.
  always @(negedge clk) begin
    ent_t e;
    if (!rst) begin
      if (pt_rd_en_o) begin
        chk("rd_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rd_idx", 32'(pt_rd_idx_o), 32'(e.idx));
          infl_q.push_back(e);
        end
      end
      if (tr_en_o) begin
        chk("wr_expected", 32'(infl_q.size() != 0), 32'd1);
        if (infl_q.size() != 0) begin
          e = infl_q.pop_front();
          chk("tr_idx", 32'(tr_idx_o), 32'(e.idx));
          chk("tr_outcome", 32'(tr_outcome_o), 32'(e.outcome));
          chk("tr_bhr", 32'(tr_bhr_o), 32'(e.bhr));
        end
      end else begin
        chk("tr_zero_idle", 32'({tr_idx_o, tr_outcome_o, tr_bhr_o}), 32'd0);
      end
      if (if_stall_o) chk("stall_needs_req_and_read", 32'({if_rd_req_i, pt_rd_en_o}), 32'd3);
    end
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    book();
  endtask

  // Present one resolution until accepted; returns just after the accepting edge.
  task automatic send(input logic [5:0] idx, input logic outcome, input logic [7:0] y);
    int n;
    res_vld_i = 1'b1; res_idx_i = idx; res_outcome_i = outcome;
    res_bhr_i = 8'($urandom); res_y_i = y;
    tick();
    n = 0;
    while (!last_acc && n < 32) begin
      adv(); tick(); n++;
    end
    chk("send_accept", 32'(last_acc), 32'd1);
    adv();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy_o && n < budget) begin
      adv(); tick(); n++;
    end
    chk("drain_busy", 32'(busy_o), 32'd0);
    chk("drain_trained", 32'(trained_cnt_o), 32'(16'(exp_trained)));
    chk("drain_skipped", 32'(skipped_cnt_o), 32'(16'(exp_skipped)));
    chk("drain_queues", 32'(exp_q.size() + infl_q.size()), 32'd0);
  endtask

  int pulses[$];
  logic [7:0] by_y[9]  = '{8'd20, 8'd21, 8'hEC, 8'hEB, 8'd0, 8'hFF, 8'h80, 8'd127, 8'd40};
  logic       by_o[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    rst = 1'b1; flush_i = 1'b0; res_vld_i = 1'b0; res_idx_i = '0;
    res_outcome_i = 1'b0; res_bhr_i = '0; res_y_i = '0; if_rd_req_i = 1'b0;
    adv(); adv();
    rst = 1'b0;
    tick();
    chk("rst_rdy", 32'(res_rdy_o), 32'd1);
    chk("rst_outs", 32'({busy_o, pt_rd_en_o, tr_en_o, if_stall_o}), 32'd0);
    chk("rst_cnts", 32'({trained_cnt_o, skipped_cnt_o}), 32'd0);

    // Single mispredict: read next cycle, write the one after.
    adv();
    send(6'd5, 1'b1, 8'hFD);
    res_vld_i = 1'b0;
    tick();
    chk("single_rd_en", 32'(pt_rd_en_o), 32'd1);
    chk("single_rd_idx", 32'(pt_rd_idx_o), 32'd5);
    chk("single_no_wr_yet", 32'(tr_en_o), 32'd0);
    adv(); tick();
    chk("single_tr_en", 32'(tr_en_o), 32'd1);
    chk("single_tr_idx", 32'(tr_idx_o), 32'd5);
    adv(); tick();
    chk("single_trained", 32'(trained_cnt_o), 32'd1);
    chk("single_idle", 32'(busy_o), 32'd0);

    // Confident and correct: filtered, never queued.
    adv();
    send(6'd9, 1'b1, 8'd40);
    res_vld_i = 1'b0;
    tick();
    chk("skip_pos_busy", 32'(busy_o), 32'd0);
    chk("skip_pos_cnt", 32'(skipped_cnt_o), 32'd1);
    adv();
    send(6'd10, 1'b0, 8'h80);
    res_vld_i = 1'b0;
    tick();
    chk("skip_neg_busy", 32'(busy_o), 32'd0);
    chk("skip_neg_cnt", 32'(skipped_cnt_o), 32'd2);

    // Threshold boundaries and sign cases, back to back.
    adv();
    for (int i = 0; i < 9; i++) send(6'(i + 20), by_o[i], by_y[i]);
    res_vld_i = 1'b0;
    tick();
    wait_idle(60);

    // Fill and back-pressure: fetch holds the port so entries pile up.
    adv();
    if_rd_req_i = 1'b1;
    for (int i = 0; i < 4; i++) send(6'(i + 40), 1'b1, 8'hF0);
    res_idx_i = 6'd44; res_bhr_i = 8'($urandom);
    tick();
    chk("fill_rdy_low", 32'(res_rdy_o), 32'd0);
    chk("fill_forced_rd", 32'({pt_rd_en_o, if_stall_o}), 32'd3);
    adv(); tick();
    chk("fill_fifth_accept", 32'(last_acc), 32'd1);
    adv();
    res_vld_i = 1'b0; if_rd_req_i = 1'b0;
    pulses.delete();
    for (int i = 0; i < 12; i++) begin
      if (i > 0) adv();
      tick();
      if (tr_en_o) pulses.push_back(i);
    end
    chk("fill_pulse_cnt", 32'(pulses.size()), 32'd4);
    for (int i = 1; i < pulses.size(); i++)
      chk("fill_pulse_gap", 32'(pulses[i] - pulses[i-1]), 32'd2);
    wait_idle(60);

    // Starvation guard: three lost cycles, then a forced slot.
    adv();
    if_rd_req_i = 1'b1;
    send(6'd33, 1'b0, 8'd5);
    res_vld_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("starve_hold", 32'({pt_rd_en_o, if_stall_o}), 32'd0);
      adv();
    end
    tick();
    chk("starve_forced", 32'({pt_rd_en_o, if_stall_o}), 32'd3);
    chk("starve_idx", 32'(pt_rd_idx_o), 32'd33);
    adv();
    if_rd_req_i = 1'b0;
    tick();
    chk("starve_write", 32'(tr_en_o), 32'd1);
    wait_idle(60);

    // Flush during WRITE: that write completes, the rest are dropped.
    adv();
    if_rd_req_i = 1'b1;
    for (int i = 0; i < 3; i++) send(6'(i + 50), 1'b1, 8'hE0);
    res_vld_i = 1'b0;
    tick();
    chk("flush_pre_rd", 32'(pt_rd_en_o), 32'd0);
    adv(); tick();
    chk("flush_rd", 32'(pt_rd_en_o), 32'd1);
    adv();
    flush_i = 1'b1; if_rd_req_i = 1'b0;
    tick();
    chk("flush_wr_completes", 32'(tr_en_o), 32'd1);
    adv();
    flush_i = 1'b0;
    tick();
    chk("flush_busy_low", 32'(busy_o), 32'd0);
    chk("flush_no_wr", 32'(tr_en_o), 32'd0);
    wait_idle(20);

    // Reset while stalled in READ.
    adv();
    if_rd_req_i = 1'b1;
    send(6'd60, 1'b1, 8'hC0);
    res_vld_i = 1'b0;
    tick(); adv(); tick(); adv();
    rst = 1'b1;
    tick(); adv();
    rst = 1'b0; if_rd_req_i = 1'b0;
    tick();
    chk("rst2_rdy", 32'(res_rdy_o), 32'd1);
    chk("rst2_outs", 32'({busy_o, pt_rd_en_o, tr_en_o, if_stall_o, pt_rd_idx_o}), 32'd0);
    chk("rst2_cnts", 32'({trained_cnt_o, skipped_cnt_o}), 32'd0);

    // Randomized traffic.
    adv();
    for (int i = 0; i < 2000; i++) begin
      res_vld_i     = 1'($urandom_range(0, 1));
      res_idx_i     = 6'($urandom);
      res_outcome_i = 1'($urandom);
      res_bhr_i     = 8'($urandom);
      if ($urandom_range(0, 1) == 0) res_y_i = 8'($urandom);
      else res_y_i = 8'(int'($urandom_range(0, 50)) - 25);
      if_rd_req_i   = ($urandom_range(0, 9) < 4);
      flush_i       = ($urandom_range(0, 59) == 0);
      tick();
      adv();
    end
    res_vld_i = 1'b0; if_rd_req_i = 1'b0; flush_i = 1'b0;
    tick();
    wait_idle(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
